// File: rtl/sargantana_icache_refill_unit.sv
// Purpose: icache miss refill. Takes one miss, issues a line-aligned L2 request, and gathers N_BEATS beats in any order into one line write.
// Latency: the last beat reaches line_we_o 1 cycle later, and miss_ready_o 2 cycles later. The delay from ack to the first beat is unbounded.
// Backpressure: miss_ready_o is high only in IDLE. The L2 request is held stable until ifill_ack_i. Response beats are never stalled.
//
// Ports: clk_i/rst_i (synchronous, active-high); miss_* (request from the icache controller);
//        kill_i (abort refill); ifill_req_* / ifill_ack_i (L2 request); ifill_resp_* (L2 beats);
//        inv_* (invalidation snoop); line_* (line write into the data/tag arrays); busy_o.
// Optional: define ICACHE_REFILL_CWF_EN to add cwf_valid_o/cwf_data_o (critical-word-first bypass).
module sargantana_icache_refill_unit #(
    parameter  int LINE_WIDTH   = 256,
    parameter  int BEAT_WIDTH   = 64,
    parameter  int N_WAY        = 4,
    parameter  int PADDR_SIZE   = 40,
    parameter  int IDX_WIDTH    = 7,
    parameter  int OFFSET_WIDTH = 5,
    localparam int N_BEATS      = LINE_WIDTH / BEAT_WIDTH,
    localparam int BEAT_IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1,
    localparam int WAY_W        = $clog2(N_WAY),
    localparam int TAG_W        = PADDR_SIZE - IDX_WIDTH - OFFSET_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    miss_valid_i,
    output logic                    miss_ready_o,
    input  logic [WAY_W-1:0]        miss_way_i,
    input  logic [PADDR_SIZE-1:0]   miss_paddr_i,
    input  logic                    kill_i,
    output logic                    ifill_req_valid_o,
    output logic [WAY_W-1:0]        ifill_req_way_o,
    output logic [PADDR_SIZE-1:0]   ifill_req_paddr_o,
    input  logic                    ifill_ack_i,
    input  logic                    ifill_resp_valid_i,
    input  logic [BEAT_IDX_W-1:0]   ifill_resp_beat_i,
    input  logic [BEAT_WIDTH-1:0]   ifill_resp_data_i,
    input  logic                    inv_valid_i,
    input  logic [11:0]             inv_paddr_i,
    output logic                    line_we_o,
    output logic [WAY_W-1:0]        line_way_o,
    output logic [IDX_WIDTH-1:0]    line_idx_o,
    output logic [TAG_W-1:0]        line_tag_o,
    output logic [LINE_WIDTH-1:0]   line_data_o,
`ifdef ICACHE_REFILL_CWF_EN
    output logic                    cwf_valid_o,
    output logic [BEAT_WIDTH-1:0]   cwf_data_o,
`endif
    output logic                    busy_o
);

    localparam int LA_W = PADDR_SIZE - OFFSET_WIDTH;

    typedef enum logic [2:0] {IDLE, REQ, FILL, WRITE, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [WAY_W-1:0]       way_q, way_d;
    logic [LA_W-1:0]        line_addr_q, line_addr_d;   // line address: tag + index
    logic [N_BEATS-1:0]     mask_q, mask_d;
    logic                   killed_q, killed_d;
    logic                   stale_q, stale_d;
    logic [LINE_WIDTH-1:0]  line_q, line_d;

    logic                   beat_take;
    logic [N_BEATS-1:0]     beat_oh;
    logic [N_BEATS-1:0]     mask_nxt;
    logic                   mask_full;
    logic                   inv_hit;

    // The L2 may only answer once it has acked, so beats before the ack cycle are not ours.
    assign beat_take = ifill_resp_valid_i &&
                       ((state_q == FILL) || (state_q == DRAIN) ||
                        ((state_q == REQ) && ifill_ack_i));
    assign beat_oh   = beat_take ? (N_BEATS'(1) << ifill_resp_beat_i) : '0;
    assign mask_nxt  = mask_q | beat_oh;
    assign mask_full = &mask_nxt;

    assign inv_hit = inv_valid_i &&
                     (inv_paddr_i[OFFSET_WIDTH +: IDX_WIDTH] == line_addr_q[IDX_WIDTH-1:0]) &&
                     ((state_q == REQ) || (state_q == FILL) || (state_q == WRITE));

    always_comb begin
        state_d     = state_q;
        way_d       = way_q;
        line_addr_d = line_addr_q;
        mask_d      = mask_q;
        killed_d    = killed_q;
        stale_d     = stale_q;
        line_d      = line_q;

        case (state_q)
            IDLE: begin
                if (miss_valid_i && !kill_i) begin
                    state_d     = REQ;
                    way_d       = miss_way_i;
                    line_addr_d = miss_paddr_i[PADDR_SIZE-1:OFFSET_WIDTH];
                    mask_d      = '0;
                    killed_d    = 1'b0;
                    stale_d     = 1'b0;
                end
            end
            REQ: begin
                // A request already on the bus cannot be withdrawn; a kill only marks it for draining.
                killed_d = killed_q | kill_i;
                stale_d  = stale_q | inv_hit;
                mask_d   = mask_nxt;
                if (ifill_ack_i) begin
                    if (killed_q || kill_i) state_d = mask_full ? IDLE  : DRAIN;
                    else                    state_d = mask_full ? WRITE : FILL;
                end
            end
            FILL: begin
                stale_d = stale_q | inv_hit;
                mask_d  = mask_nxt;
                if (kill_i) begin
                    killed_d = 1'b1;
                    state_d  = mask_full ? IDLE : DRAIN;
                end else if (mask_full) begin
                    state_d = WRITE;
                end
            end
            DRAIN: begin
                mask_d = mask_nxt;
                if (mask_full) state_d = IDLE;
            end
            WRITE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A repeated beat index simply overwrites its slice.
        if (beat_take && (state_q != DRAIN)) begin
            for (int k = 0; k < N_BEATS; k++) begin
                if (ifill_resp_beat_i == BEAT_IDX_W'(k))
                    line_d[k*BEAT_WIDTH +: BEAT_WIDTH] = ifill_resp_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            way_q       <= '0;
            line_addr_q <= '0;
            mask_q      <= '0;
            killed_q    <= 1'b0;
            stale_q     <= 1'b0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            way_q       <= way_d;
            line_addr_q <= line_addr_d;
            mask_q      <= mask_d;
            killed_q    <= killed_d;
            stale_q     <= stale_d;
            line_q      <= line_d;
        end
    end

    assign miss_ready_o      = (state_q == IDLE);
    assign busy_o            = (state_q != IDLE);
    assign ifill_req_valid_o = (state_q == REQ);
    assign ifill_req_way_o   = way_q;
    assign ifill_req_paddr_o = {line_addr_q, {OFFSET_WIDTH{1'b0}}};
    // An invalidation in the write cycle itself must also block the write.
    assign line_we_o         = (state_q == WRITE) && !stale_q && !inv_hit;
    assign line_way_o        = way_q;
    assign line_idx_o        = line_addr_q[IDX_WIDTH-1:0];
    assign line_tag_o        = line_addr_q[LA_W-1 -: TAG_W];
    assign line_data_o       = line_q;

    // Only the index bits of the snoop address matter; the miss offset bits only matter for CWF.
    logic unused_bits;
    assign unused_bits = ^{inv_paddr_i, miss_paddr_i[OFFSET_WIDTH-1:0]};

`ifdef ICACHE_REFILL_CWF_EN
    logic [BEAT_IDX_W-1:0] crit_q, crit_d;
    logic                  cwf_vld_q, cwf_vld_d;
    logic [BEAT_WIDTH-1:0] cwf_dat_q;

    always_comb begin
        crit_d = crit_q;
        if ((state_q == IDLE) && miss_valid_i && !kill_i)
            crit_d = miss_paddr_i[OFFSET_WIDTH-1 -: BEAT_IDX_W];
        // Forward the critical word once, on its first arrival, and only for a live, non-stale refill.
        cwf_vld_d = beat_take && (state_q != DRAIN) &&
                    (ifill_resp_beat_i == crit_q) && !mask_q[crit_q] &&
                    !(killed_q || kill_i) && !(stale_q || inv_hit);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crit_q    <= '0;
            cwf_vld_q <= 1'b0;
            cwf_dat_q <= '0;
        end else begin
            crit_q    <= crit_d;
            cwf_vld_q <= cwf_vld_d;
            if (cwf_vld_d) cwf_dat_q <= ifill_resp_data_i;
        end
    end

    assign cwf_valid_o = cwf_vld_q;
    assign cwf_data_o  = cwf_dat_q;
`endif

endmodule

// File: tb/tb_sargantana_icache_refill_unit.sv
// Purpose: directed self-checking bench for sargantana_icache_refill_unit.
// Latency: inputs are driven 1 ns after posedge and checked 2 ns after posedge; line writes are counted on negedge.
// Backpressure: none modelled; the bench acts as the icache controller and as the L2.
module tb_sargantana_icache_refill_unit;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         miss_valid_i;
    logic         miss_ready_o;
    logic [1:0]   miss_way_i;
    logic [39:0]  miss_paddr_i;
    logic         kill_i;
    logic         ifill_req_valid_o;
    logic [1:0]   ifill_req_way_o;
    logic [39:0]  ifill_req_paddr_o;
    logic         ifill_ack_i;
    logic         ifill_resp_valid_i;
    logic [1:0]   ifill_resp_beat_i;
    logic [63:0]  ifill_resp_data_i;
    logic         inv_valid_i;
    logic [11:0]  inv_paddr_i;
    logic         line_we_o;
    logic [1:0]   line_way_o;
    logic [6:0]   line_idx_o;
    logic [27:0]  line_tag_o;
    logic [255:0] line_data_o;
    logic         busy_o;
`ifdef ICACHE_REFILL_CWF_EN
    logic         cwf_valid_o;
    logic [63:0]  cwf_data_o;
`endif

    sargantana_icache_refill_unit dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .miss_valid_i       (miss_valid_i),
        .miss_ready_o       (miss_ready_o),
        .miss_way_i         (miss_way_i),
        .miss_paddr_i       (miss_paddr_i),
        .kill_i             (kill_i),
        .ifill_req_valid_o  (ifill_req_valid_o),
        .ifill_req_way_o    (ifill_req_way_o),
        .ifill_req_paddr_o  (ifill_req_paddr_o),
        .ifill_ack_i        (ifill_ack_i),
        .ifill_resp_valid_i (ifill_resp_valid_i),
        .ifill_resp_beat_i  (ifill_resp_beat_i),
        .ifill_resp_data_i  (ifill_resp_data_i),
        .inv_valid_i        (inv_valid_i),
        .inv_paddr_i        (inv_paddr_i),
        .line_we_o          (line_we_o),
        .line_way_o         (line_way_o),
        .line_idx_o         (line_idx_o),
        .line_tag_o         (line_tag_o),
        .line_data_o        (line_data_o),
`ifdef ICACHE_REFILL_CWF_EN
        .cwf_valid_o        (cwf_valid_o),
        .cwf_data_o         (cwf_data_o),
`endif
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [63:0]  D0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0]  D1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0]  D2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0]  D3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0]  DA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0]  DB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [255:0] LINE_EXP = {D3, D2, D1, D0};
    localparam logic [39:0]  PA = 40'h00_8000_1234;

    int n_pass  = 0;
    int n_total = 0;
    int we_cnt  = 0;
    int base;

    always @(negedge clk_i) if (line_we_o === 1'b1) we_cnt++;

    // ---- stimulus helpers (no checks) ----
    task automatic tick();
        @(posedge clk_i); #2;
    endtask

    task automatic start_miss(input logic [39:0] pa, input logic [1:0] w);
        miss_valid_i = 1'b1; miss_paddr_i = pa; miss_way_i = w;
        @(posedge clk_i); #1 miss_valid_i = 1'b0; #1;
    endtask

    task automatic ack();
        ifill_ack_i = 1'b1;
        @(posedge clk_i); #1 ifill_ack_i = 1'b0; #1;
    endtask

    task automatic beat(input logic [1:0] b, input logic [63:0] d);
        ifill_resp_valid_i = 1'b1; ifill_resp_beat_i = b; ifill_resp_data_i = d;
        @(posedge clk_i); #1 ifill_resp_valid_i = 1'b0; #1;
    endtask

    task automatic kill_pulse();
        kill_i = 1'b1;
        @(posedge clk_i); #1 kill_i = 1'b0; #1;
    endtask

    task automatic inv_pulse(input logic [11:0] a);
        inv_valid_i = 1'b1; inv_paddr_i = a;
        @(posedge clk_i); #1 inv_valid_i = 1'b0; #1;
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0; #1;
        n_total++; if (miss_ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", miss_ready_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
        n_total++; if (ifill_req_valid_o !== 1'b0) $display("FAIL reset_req: got %b want 0", ifill_req_valid_o); else n_pass++;
        n_total++; if (line_we_o !== 1'b0) $display("FAIL reset_we: got %b want 0", line_we_o); else n_pass++;
        n_total++; if (line_data_o !== 256'h0) $display("FAIL reset_data: got %h want 0", line_data_o); else n_pass++;
    endtask

    task automatic test_basic();
        base = we_cnt;
        start_miss(PA, 2'd2);
        n_total++; if (ifill_req_valid_o !== 1'b1) $display("FAIL basic_req_valid: got %b want 1", ifill_req_valid_o); else n_pass++;
        n_total++; if (ifill_req_paddr_o !== 40'h00_8000_1220) $display("FAIL basic_req_paddr: got %h want 0080001220", ifill_req_paddr_o); else n_pass++;
        n_total++; if (miss_ready_o !== 1'b0) $display("FAIL basic_ready_low: got %b want 0", miss_ready_o); else n_pass++;
        tick(); tick();
        n_total++; if ({ifill_req_valid_o, ifill_req_way_o} !== 3'b1_10) $display("FAIL basic_req_held: got %b want 110", {ifill_req_valid_o, ifill_req_way_o}); else n_pass++;
        ack();
        n_total++; if (ifill_req_valid_o !== 1'b0) $display("FAIL basic_req_drop: got %b want 0", ifill_req_valid_o); else n_pass++;
        beat(2'd0, D0); beat(2'd1, D1); beat(2'd2, D2); beat(2'd3, D3);
        n_total++; if (line_we_o !== 1'b1) $display("FAIL basic_we: got %b want 1", line_we_o); else n_pass++;
        n_total++; if (line_idx_o !== 7'h11) $display("FAIL basic_idx: got %h want 11", line_idx_o); else n_pass++;
        n_total++; if (line_way_o !== 2'd2) $display("FAIL basic_way: got %0d want 2", line_way_o); else n_pass++;
        n_total++; if (line_tag_o !== 28'h0080001) $display("FAIL basic_tag: got %h want 0080001", line_tag_o); else n_pass++;
        n_total++; if (line_data_o !== LINE_EXP) $display("FAIL basic_data: got %h want %h", line_data_o, LINE_EXP); else n_pass++;
        tick();
        n_total++; if (miss_ready_o !== 1'b1) $display("FAIL basic_ready_back: got %b want 1", miss_ready_o); else n_pass++;
        n_total++; if (we_cnt - base !== 1) $display("FAIL basic_we_count: got %0d want 1", we_cnt - base); else n_pass++;
    endtask

    task automatic test_out_of_order();
        base = we_cnt;
        start_miss(PA, 2'd1);
        ack();
        beat(2'd2, D2); beat(2'd0, D0); beat(2'd3, D3);
        n_total++; if ({busy_o, line_we_o} !== 2'b10) $display("FAIL ooo_not_done: got %b want 10", {busy_o, line_we_o}); else n_pass++;
        beat(2'd1, D1);
        n_total++; if (line_we_o !== 1'b1) $display("FAIL ooo_we: got %b want 1", line_we_o); else n_pass++;
        n_total++; if (line_data_o !== LINE_EXP) $display("FAIL ooo_data: got %h want %h", line_data_o, LINE_EXP); else n_pass++;
        n_total++; if (line_way_o !== 2'd1) $display("FAIL ooo_way: got %0d want 1", line_way_o); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 1) $display("FAIL ooo_we_count: got %0d want 1", we_cnt - base); else n_pass++;
    endtask

    task automatic test_duplicate();
        base = we_cnt;
        start_miss(PA, 2'd3);
        ack();
        beat(2'd1, DA); beat(2'd1, DB); beat(2'd0, D0); beat(2'd2, D2);
        n_total++; if (line_we_o !== 1'b0) $display("FAIL dup_early_we: got %b want 0", line_we_o); else n_pass++;
        beat(2'd3, D3);
        n_total++; if (line_we_o !== 1'b1) $display("FAIL dup_we: got %b want 1", line_we_o); else n_pass++;
        n_total++; if (line_data_o !== {D3, D2, DB, D0}) $display("FAIL dup_data: got %h want %h", line_data_o, {D3, D2, DB, D0}); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 1) $display("FAIL dup_we_count: got %0d want 1", we_cnt - base); else n_pass++;
    endtask

    task automatic test_kill();
        base = we_cnt;
        start_miss(PA, 2'd0);
        ack();
        beat(2'd1, D1);
        kill_pulse();
        beat(2'd0, D0); beat(2'd2, D2);
        n_total++; if (busy_o !== 1'b1) $display("FAIL kill_busy: got %b want 1", busy_o); else n_pass++;
        beat(2'd3, D3);
        n_total++; if ({miss_ready_o, busy_o} !== 2'b10) $display("FAIL kill_idle: got %b want 10", {miss_ready_o, busy_o}); else n_pass++;
        tick(); tick();
        n_total++; if (we_cnt - base !== 0) $display("FAIL kill_no_write: got %0d want 0", we_cnt - base); else n_pass++;
    endtask

    task automatic test_kill_in_req();
        base = we_cnt;
        start_miss(PA, 2'd0);
        kill_pulse();
        n_total++; if (ifill_req_valid_o !== 1'b1) $display("FAIL killreq_held: got %b want 1", ifill_req_valid_o); else n_pass++;
        ack();
        beat(2'd0, D0); beat(2'd1, D1); beat(2'd2, D2); beat(2'd3, D3);
        n_total++; if (miss_ready_o !== 1'b1) $display("FAIL killreq_idle: got %b want 1", miss_ready_o); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 0) $display("FAIL killreq_no_write: got %0d want 0", we_cnt - base); else n_pass++;
    endtask

    task automatic test_miss_with_kill();
        miss_valid_i = 1'b1; miss_paddr_i = PA; miss_way_i = 2'd0; kill_i = 1'b1;
        @(posedge clk_i); #1 miss_valid_i = 1'b0; kill_i = 1'b0; #1;
        n_total++; if (busy_o !== 1'b0) $display("FAIL misskill_rejected: got busy %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_inv();
        base = we_cnt;
        start_miss(PA, 2'd0);
        ack();
        beat(2'd0, D0);
        inv_pulse(12'h220);
        beat(2'd1, D1); beat(2'd2, D2); beat(2'd3, D3);
        n_total++; if ({busy_o, line_we_o} !== 2'b10) $display("FAIL inv_hit_we: got %b want 10", {busy_o, line_we_o}); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 0) $display("FAIL inv_hit_count: got %0d want 0", we_cnt - base); else n_pass++;

        base = we_cnt;
        start_miss(PA, 2'd0);
        ack();
        beat(2'd0, D0);
        inv_pulse(12'h240);
        beat(2'd1, D1); beat(2'd2, D2); beat(2'd3, D3);
        n_total++; if (line_we_o !== 1'b1) $display("FAIL inv_miss_we: got %b want 1", line_we_o); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 1) $display("FAIL inv_miss_count: got %0d want 1", we_cnt - base); else n_pass++;

        base = we_cnt;
        start_miss(PA, 2'd0);
        ack();
        beat(2'd0, D0); beat(2'd1, D1); beat(2'd2, D2); beat(2'd3, D3);
        inv_valid_i = 1'b1; inv_paddr_i = 12'h220; #1;
        n_total++; if (line_we_o !== 1'b0) $display("FAIL inv_same_cycle_we: got %b want 0", line_we_o); else n_pass++;
        @(posedge clk_i); #1 inv_valid_i = 1'b0; #1;
        n_total++; if (we_cnt - base !== 0) $display("FAIL inv_same_cycle_count: got %0d want 0", we_cnt - base); else n_pass++;
    endtask

    task automatic test_reset_mid();
        base = we_cnt;
        start_miss(PA, 2'd2);
        ack();
        beat(2'd0, D0);
        rst_i = 1'b1;
        @(posedge clk_i); #1 rst_i = 1'b0; #1;
        n_total++; if ({miss_ready_o, busy_o} !== 2'b10) $display("FAIL rstmid_idle: got %b want 10", {miss_ready_o, busy_o}); else n_pass++;
        beat(2'd1, D1);
        n_total++; if (busy_o !== 1'b0) $display("FAIL rstmid_late_beat: got busy %b want 0", busy_o); else n_pass++;
        start_miss(PA, 2'd2);
        ack();
        beat(2'd3, D3); beat(2'd2, D2); beat(2'd1, D1);
        n_total++; if (line_we_o !== 1'b0) $display("FAIL rstmid_partial: got %b want 0", line_we_o); else n_pass++;
        beat(2'd0, D0);
        n_total++; if (line_data_o !== LINE_EXP) $display("FAIL rstmid_data: got %h want %h", line_data_o, LINE_EXP); else n_pass++;
        tick();
        n_total++; if (we_cnt - base !== 1) $display("FAIL rstmid_count: got %0d want 1", we_cnt - base); else n_pass++;
    endtask

`ifdef ICACHE_REFILL_CWF_EN
    task automatic test_cwf();
        start_miss(40'h00_8000_1218, 2'd1);
        ack();
        beat(2'd0, D0); beat(2'd1, D1); beat(2'd2, D2);
        n_total++; if (cwf_valid_o !== 1'b0) $display("FAIL cwf_early: got %b want 0", cwf_valid_o); else n_pass++;
        beat(2'd3, D3);
        n_total++; if (cwf_valid_o !== 1'b1) $display("FAIL cwf_valid: got %b want 1", cwf_valid_o); else n_pass++;
        n_total++; if (cwf_data_o !== D3) $display("FAIL cwf_data: got %h want %h", cwf_data_o, D3); else n_pass++;
        tick();
        n_total++; if (cwf_valid_o !== 1'b0) $display("FAIL cwf_pulse: got %b want 0", cwf_valid_o); else n_pass++;
    endtask
`endif

    initial begin
        rst_i = 1'b1; miss_valid_i = 1'b0; miss_way_i = '0; miss_paddr_i = '0; kill_i = 1'b0;
        ifill_ack_i = 1'b0; ifill_resp_valid_i = 1'b0; ifill_resp_beat_i = '0; ifill_resp_data_i = '0;
        inv_valid_i = 1'b0; inv_paddr_i = '0;
        test_reset();
        test_basic();
        test_out_of_order();
        test_duplicate();
        test_kill();
        test_kill_in_req();
        test_miss_with_kill();
        test_inv();
        test_reset_mid();
`ifdef ICACHE_REFILL_CWF_EN
        test_cwf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_refill_unit.md
Name: sargantana_icache_refill_unit

Overview:
Parametrised successor to the fixed 256-bit, single-response icache IFILL path. It accepts one icache miss, issues a line-aligned refill request to L2 and collects N_BEATS beats in any order. It then writes one assembled line into the selected way. It also handles kill mid-refill (drain without write) and invalidation races (refill dropped if its index is invalidated in flight). It sits between the icache controller and the L2 ifill interface.

Parameters:
LINE_WIDTH, 256, cache line bits
BEAT_WIDTH, 64, bits per L2 response beat; LINE_WIDTH % BEAT_WIDTH == 0
N_BEATS, LINE_WIDTH/BEAT_WIDTH (derived), beats per line; BEAT_IDX_W = max(1,$clog2(N_BEATS))
N_WAY, 4, associativity; WAY_W = $clog2(N_WAY)
PADDR_SIZE, 40, physical address bits
IDX_WIDTH, 7, set index bits
OFFSET_WIDTH, 5, line offset bits; OFFSET_WIDTH+IDX_WIDTH <= 12
TAG_W, PADDR_SIZE-IDX_WIDTH-OFFSET_WIDTH (derived), tag bits

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
miss_valid_i  in  1  miss request
miss_ready_o  out  1  unit idle, miss accepted when valid&ready
miss_way_i  in  WAY_W  victim way
miss_paddr_i  in  PADDR_SIZE  miss physical address
kill_i  in  1  abort current refill
ifill_req_valid_o  out  1  L2 refill request
ifill_req_way_o  out  WAY_W  latched way
ifill_req_paddr_o  out  PADDR_SIZE  latched paddr, low OFFSET_WIDTH bits forced 0
ifill_ack_i  in  1  L2 accepted request
ifill_resp_valid_i  in  1  beat valid
ifill_resp_beat_i  in  BEAT_IDX_W  beat index
ifill_resp_data_i  in  BEAT_WIDTH  beat data
inv_valid_i  in  1  invalidation
inv_paddr_i  in  12  invalidation address
line_we_o  out  1  one-cycle line write strobe
line_way_o  out  WAY_W  way to write
line_idx_o  out  IDX_WIDTH  set index
line_tag_o  out  TAG_W  tag to write
line_data_o  out  LINE_WIDTH  assembled line, beat k at bits [k*BEAT_WIDTH +: BEAT_WIDTH]
busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0 except miss_ready_o=1. Beat mask, kill and stale flags cleared. Reset mid-refill discards everything, including late L2 beats.
- States: IDLE, REQ, FILL, WRITE, DRAIN.
- IDLE: miss_valid_i&&!kill_i latches way/paddr and moves to REQ next cycle. A miss presented with kill_i in the same cycle is not accepted.
- REQ: ifill_req_valid_o=1, held with stable way/paddr until ifill_ack_i. kill_i in REQ sets the killed flag; the request is never withdrawn.
  - On ack: killed -> DRAIN, else -> FILL.
  - Beats arriving in the ack cycle are captured.
- FILL: each valid beat writes its slice and sets mask[beat].
  - Duplicate beat index overwrites data and does not advance completion.
  - Mask all-ones (including the beat arriving this cycle) -> WRITE next cycle.
  - kill_i in FILL -> DRAIN; mask is preserved so remaining beats are counted.
- DRAIN: beats are consumed and discarded. Mask full -> IDLE, no line write.
- WRITE: line_we_o=1 for exactly one cycle with way/idx/tag/data valid, unless the stale flag is set (line_we_o=0). Then -> IDLE. kill_i in WRITE is ignored; the line is complete and valid.
- Invalidation: inv_valid_i with inv_paddr_i[OFFSET_WIDTH+:IDX_WIDTH] == latched index while in REQ/FILL/WRITE sets the stale flag. Same-cycle inv and WRITE: the write is suppressed. Inv in IDLE or with a different index: no effect.
- Latency: ack to first beat is unbounded. Last beat to line_we_o is 1 cycle. Last beat to miss_ready_o=1 is 2 cycles.
- Beats with ifill_resp_valid_i in IDLE are ignored.

Optional Feature:
ICACHE_REFILL_CWF_EN:
- Defined: adds outputs cwf_valid_o (1) and cwf_data_o (BEAT_WIDTH). cwf_valid_o pulses 1 cycle after the beat whose index equals paddr[OFFSET_WIDTH-1 -: BEAT_IDX_W] arrives in FILL, carrying that beat for early fetch. It is suppressed if killed or stale.
- Undefined: ports absent, no critical-word logic.

Test Plan:
- Miss paddr 0x80001234, way 2; ack after 3 cycles; beats 0,1,2,3 with data 0x11..,0x22..,0x33..,0x44.. -> ifill_req_paddr_o=0x80001220; one line_we_o, idx=0x11, way=2, data={0x44..,0x33..,0x22..,0x11..}.
- Beats arriving in order 2,0,3,1 -> identical line layout; line_we_o 1 cycle after beat 1.
- Duplicate beat 1 (0xAA then 0xBB) followed by beats 0,2,3 -> slice 1 = 0xBB; exactly one write, only after all 4 indices are seen.
- kill_i after beat 1 -> no line_we_o; busy_o stays high until beats 0,2,3 are drained; miss_ready_o=1 next cycle.
- inv_valid_i with inv_paddr_i index 0x11 during FILL -> refill completes, line_we_o stays 0. Index 0x12 -> normal write.
- ICACHE_REFILL_CWF_EN, paddr offset 0x18 -> cwf_valid_o pulses after beat 3 arrives, cwf_data_o = beat 3 data.
